// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding and default baud timing for 125 MHz.
package uart_rx_pkg;

    localparam int unsigned UartSlowBit = 1085;
    localparam int unsigned UartFastBit = 31;
    localparam int unsigned CntWidth    = 11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level.
module sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8n1 UART receiver with two selectable bit rates, valid/ready byte output and
// single-cycle framing-error and overflow pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned SLOW_BIT = UartSlowBit,
    parameter int unsigned FAST_BIT = UartFastBit
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       high_speed,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_error,
    output logic       overflow
);

    localparam logic [CntWidth-1:0] SlowLen = CntWidth'(SLOW_BIT);
    localparam logic [CntWidth-1:0] FastLen = CntWidth'(FAST_BIT);

    logic                rxs;
    rx_state_e           state_q;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] bit_len_q;
    logic [CntWidth-1:0] new_len;
    logic                cnt_zero;
    logic [2:0]          idx_q;
    logic [7:0]          shift_q;
    logic [7:0]          data_q;
    logic                valid_q;
    logic                frame_error_q;
    logic                overflow_q;

    sync2 #(
        .ResetVal(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rxs)
    );

    assign new_len  = high_speed ? FastLen : SlowLen;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bit_len_q     <= SlowLen;
            idx_q         <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
            // Free-running decrement; states that reload override it below.
            if (!cnt_zero) begin
                cnt_q <= cnt_q - CntWidth'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (!rxs) begin
                        bit_len_q <= new_len;
                        cnt_q     <= (new_len >> 1) - CntWidth'(1);
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_zero) begin
                        if (rxs) begin
                            state_q <= StIdle;
                        end else begin
                            cnt_q   <= bit_len_q - CntWidth'(1);
                            idx_q   <= '0;
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (cnt_zero) begin
                        shift_q <= {rxs, shift_q[7:1]};
                        cnt_q   <= bit_len_q - CntWidth'(1);
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (cnt_zero) begin
                        if (rxs) begin
                            state_q <= StIdle;
                            // A new byte may replace one being consumed this same cycle.
                            if (!valid_q || ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end else begin
                            frame_error_q <= 1'b1;
                            state_q       <= StBreak;
                        end
                    end
                end
                StBreak: begin
                    if (rxs) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are built bit by bit from a byte model,
// expected bytes are queued at send time and popped by a monitor on each handshake.
module tb_uart_rx;

    localparam int unsigned SlowBit = 1085;
    localparam int unsigned FastBit = 31;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       rx         = 1'b1;
    logic       high_speed = 1'b0;
    logic       ready      = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_error;
    logic       overflow;

    uart_rx #(
        .SLOW_BIT(SlowBit),
        .FAST_BIT(FastBit)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .high_speed (high_speed),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_error(frame_error),
        .overflow   (overflow)
    );

    always #4 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;

    logic [7:0]  exp_q[$];
    int          exp_fe      = 0;
    int          exp_ov      = 0;
    int          fe_cnt      = 0;
    int          ov_cnt      = 0;
    int          rise_cnt    = 0;
    int          valid_hi    = 0;
    int unsigned last_rise   = 0;
    logic        valid_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (valid && !valid_prev) begin
            last_rise = cyc;
            rise_cnt++;
        end
        valid_prev = valid;
        if (valid) valid_hi++;
        if (frame_error) fe_cnt++;
        if (overflow) ov_cnt++;
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_byte: got %02h, required no byte", data);
            end else begin
                check("rx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int unsigned bit_of(input logic hs);
        return hs ? FastBit : SlowBit;
    endfunction

    // Cycles from the line edge to valid: sync, half bit, nine full bits, output register.
    function automatic int unsigned latency_of(input logic hs);
        return 3 + (bit_of(hs) >> 1) + 9 * bit_of(hs);
    endfunction

    // Drives the first nbits of an 8n1 frame; optionally wiggles high_speed after the start bit.
    task automatic send_bits(input logic [7:0] b, input logic hs, input logic stop,
                             input int nbits, input logic scramble);
        logic [9:0] frame;
        frame      = {stop, b, 1'b0};
        high_speed = hs;
        for (int i = 0; i < nbits; i++) begin
            rx = frame[i];
            if (i == 1 && scramble) high_speed = 1'($urandom);
            tick(bit_of(hs));
        end
        high_speed = hs;
    endtask

    // Reference model: a good stop bit yields the byte unless a pending byte blocks it.
    task automatic frame(input logic [7:0] b, input logic hs, input logic stop,
                         input logic deliverable, input logic scramble);
        if (!stop) exp_fe++;
        else if (deliverable) exp_q.push_back(b);
        else exp_ov++;
        send_bits(b, hs, stop, 10, scramble);
    endtask

    initial begin
        #(8 * 150000);
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned fall_cyc;
        int          r0;
        int          f0;
        int          v0;

        tick(3);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_data", {24'd0, data}, 32'd0);
        check("reset_frame_error", {31'd0, frame_error}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Slow rate, exact latency and one-cycle valid with ready held high.
        v0       = valid_hi;
        fall_cyc = cyc;
        frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
        tick(20);
        check("slow_latency", last_rise - fall_cyc, latency_of(1'b0));
        check("slow_valid_width", valid_hi - v0, 1);

        // Fast rate, back-to-back frames.
        f0 = fe_cnt;
        frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
        frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(40);
        check("b2b_drained", exp_q.size(), 0);
        check("b2b_no_fe", fe_cnt - f0, 0);

        // Short glitch on an idle line.
        r0 = rise_cnt;
        f0 = fe_cnt;
        high_speed = 1'b1;
        rx = 1'b0;
        tick(10);
        rx = 1'b1;
        tick(100);
        check("glitch_no_valid", rise_cnt - r0, 0);
        check("glitch_no_fe", fe_cnt - f0, 0);

        // Framing error followed by a long break, then a good frame.
        r0 = rise_cnt;
        f0 = fe_cnt;
        frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        rx = 1'b0;
        tick(20 * FastBit);
        rx = 1'b1;
        tick(2 * FastBit);
        check("break_one_fe", fe_cnt - f0, 1);
        check("break_no_valid", rise_cnt - r0, 0);
        frame(8'h12, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(40);
        check("after_break_drained", exp_q.size(), 0);

        // Overflow while the consumer stalls.
        ready = 1'b0;
        frame(8'h11, 1'b1, 1'b1, 1'b1, 1'b0);
        frame(8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(40);
        check("stall_valid", {31'd0, valid}, 32'd1);
        check("stall_data", {24'd0, data}, 32'h11);
        check("stall_overflow", ov_cnt, exp_ov);
        ready = 1'b1;
        tick(3);
        check("drain_valid", {31'd0, valid}, 32'd0);
        check("drain_data", {24'd0, data}, 32'h11);
        check("drain_queue", exp_q.size(), 0);

        // Reset in the middle of a frame aborts it silently.
        r0 = rise_cnt;
        send_bits(8'h77, 1'b1, 1'b1, 4, 1'b0);
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(5);
        check("midreset_data", {24'd0, data}, 32'd0);
        rst_n = 1'b1;
        tick(2 * 10 * FastBit);
        check("midreset_no_valid", rise_cnt - r0, 0);
        frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(40);
        check("after_reset_drained", exp_q.size(), 0);

        // Random bytes, random gaps, high_speed wiggled mid-frame.
        for (int i = 0; i < 24; i++) begin
            frame(8'($urandom), 1'b1, 1'b1, 1'b1, 1'b1);
            tick($urandom_range(0, 40));
        end
        tick(60);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_frame_errors", fe_cnt, exp_fe);
        check("final_overflows", ov_cnt, exp_ov);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
